// File: rtl/timer_pkg.sv
// Shared widths and state encodings for the down-counting timer.
package timer_pkg;
  localparam int unsigned CNT_W = 8;

  localparam logic [1:0] ST_IDLE = 2'b00;
  localparam logic [1:0] ST_RUN  = 2'b01;
  localparam logic [1:0] ST_DONE = 2'b10;
endpackage

// File: rtl/down_timer8_if.sv
// Control and status bundle for down_timer8.
interface down_timer8_if;
  import timer_pkg::*;

  logic             load;
  logic [CNT_W-1:0] in;
  logic             start;
  logic             stop;
  logic             auto;
  logic             clear;
  logic [CNT_W-1:0] count;
  logic             running;
  logic             zero;
  logic             flag;

  modport slave (
    input  load, in, start, stop, auto, clear,
    output count, running, zero, flag
  );

  modport master (
    output load, in, start, stop, auto, clear,
    input  count, running, zero, flag
  );
endinterface

// File: rtl/down_timer8_or8way.sv
// Eight-input OR reduction gate.
module Or8Way (
  input  logic [7:0] in,
  output logic       out
);
  assign out = |in;
endmodule

// File: rtl/down_timer8.sv
// Loadable 8-bit down timer with optional auto-reload and sticky expiry flag.
module down_timer8
  import timer_pkg::*;
#(
  parameter logic [CNT_W-1:0] INIT_VALUE = 8'h00
) (
  input  logic         clock,
  input  logic         reset_n,
  down_timer8_if.slave bus
);

  logic [CNT_W-1:0] r_count;
  logic [CNT_W-1:0] r_reload;
  logic [1:0]       r_state;
  logic             r_flag;

  logic [CNT_W-1:0] w_count_nxt;
  logic [CNT_W-1:0] w_reload_nxt;
  logic [1:0]       w_state_nxt;
  logic             w_flag_nxt;
  logic             w_expire;
  logic             w_any;

  // State and datapath registers
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_count  <= INIT_VALUE;
      r_reload <= INIT_VALUE;
      r_state  <= ST_IDLE;
      r_flag   <= 1'b0;
    end else begin
      r_count  <= w_count_nxt;
      r_reload <= w_reload_nxt;
      r_state  <= w_state_nxt;
      r_flag   <= w_flag_nxt;
    end
  end

  // Next-state logic; load overrides everything except the flag update
  always_comb begin
    w_count_nxt  = r_count;
    w_reload_nxt = r_reload;
    w_state_nxt  = r_state;
    w_expire     = 1'b0;

    if (bus.load) begin
      w_count_nxt  = bus.in;
      w_reload_nxt = bus.in;
      w_state_nxt  = ST_IDLE;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (bus.start && (r_count != '0)) w_state_nxt = ST_RUN;
        end
        ST_RUN: begin
          if (bus.stop) begin
            w_state_nxt = ST_IDLE;
          end else if (r_count == CNT_W'(1)) begin
            w_expire = 1'b1;
            // A zero reload cannot restart the period, so it ends like one-shot
            if (bus.auto && (r_reload != '0)) begin
              w_count_nxt = r_reload;
            end else begin
              w_count_nxt = '0;
              w_state_nxt = ST_DONE;
            end
          end else begin
            w_count_nxt = r_count - CNT_W'(1);
          end
        end
        ST_DONE: begin
          w_state_nxt = ST_DONE;
        end
        default: begin
          w_state_nxt = ST_IDLE;
        end
      endcase
    end

    w_flag_nxt = r_flag;
    if (w_expire)       w_flag_nxt = 1'b1;
    else if (bus.clear) w_flag_nxt = 1'b0;
  end

  Or8Way u_or8way (
    .in  (r_count),
    .out (w_any)
  );

  assign bus.count   = r_count;
  assign bus.running = (r_state == ST_RUN);
  assign bus.zero    = ~w_any;
  assign bus.flag    = r_flag;

endmodule

// File: doc/down_timer8.md
DOWN_TIMER8 -- requirements
Module: down_timer8

Interface
REQ-001 SHALL have parameter INIT_VALUE, default 8'h00, giving the count and reload value after reset.
REQ-002 SHALL have port clock, input, 1, the single clock; all state updates on its rising edge.
REQ-003 SHALL have port reset_n, input, 1, reset, asynchronous and active-low.
REQ-004 SHALL have port load, input, 1, which captures `in` into both count and reload.
REQ-005 SHALL have port in, input, 8, the load value.
REQ-006 SHALL have port start, input, 1, a run request.
REQ-007 SHALL have port stop, input, 1, a halt request.
REQ-008 SHALL have port auto, input, 1, which selects auto-reload on expiry.
REQ-009 SHALL have port clear, input, 1, which clears the expiry flag.
REQ-010 SHALL have port count, output, 8, the current count value.
REQ-011 SHALL have port running, output, 1, high while the state is RUN.
REQ-012 SHALL have port zero, output, 1, high when count == 0 (combinational).
REQ-013 SHALL have port flag, output, 1, a sticky expiry indication.

Function
REQ-014 SHALL implement states IDLE, RUN and DONE; running = (state == RUN).
REQ-015 load SHALL set count <= in, reload <= in and state <= IDLE; load has top priority over start, stop and decrement.
REQ-016 In IDLE, start with count != 0 SHALL move the state to RUN; start with count == 0 SHALL be ignored.
REQ-017 In RUN, with no load or stop, count SHALL decrement by 1 per cycle, modulo 8 bits; the first decrement occurs on the edge after the start edge.
REQ-018 In RUN with count == 1 and auto == 0, the next edge SHALL give count <= 0, state <= DONE, flag <= 1.
REQ-019 In RUN with count == 1 and auto == 1, the next edge SHALL give count <= reload, state stays RUN, flag <= 1 (expiry period = reload cycles).
REQ-020 If auto == 1 and reload == 0 at expiry, the block SHALL behave as auto == 0 (go to DONE).
REQ-021 In RUN, stop SHALL move the state to IDLE with count held; if start and stop are both high, stop wins.
REQ-022 In DONE, start and stop SHALL be ignored; only load or reset leaves DONE.
REQ-023 clear SHALL set flag <= 0; if an expiry and clear coincide on the same edge, the set wins (flag = 1).
REQ-024 zero SHALL equal the inverse of the 8-way OR of count, with no register stage.
REQ-025 An unused state encoding SHALL recover to IDLE on the next edge.

Reset
REQ-026 While reset_n = 0, the block SHALL asynchronously force count = INIT_VALUE, reload = INIT_VALUE, state = IDLE, flag = 0 and running = 0; zero follows count.
REQ-027 Assertion of reset_n mid-RUN SHALL abort the run immediately with no expiry flag.
REQ-028 Deassertion SHALL take effect at the next rising clock edge.

Structure
REQ-029 The state encodings (IDLE = 2'b00, RUN = 2'b01, DONE = 2'b10) SHALL be defined in shared package timer_pkg.
REQ-030 Zero detect SHALL be a single instance of the existing Or8Way gate followed by Not; no other sub-module is required.
REQ-031 The count register, reload register, state register and flag SHALL be the only storage.

Verification
REQ-032 Load 8'h03, start, auto = 0 -> count 3, 2, 1, 0 on successive edges; flag = 1, running = 0 and zero = 1 on the edge where count reaches 0.
REQ-033 Load 8'h02, auto = 1, start, run 6 cycles -> count 2, 1, 2, 1, 2, 1; flag sets at the first expiry; running stays 1.
REQ-034 Load 8'h05, start, stop after 2 decrements -> count holds 3, state IDLE; a new start resumes 3 -> 2.
REQ-035 Expiry and clear on the same edge -> flag = 1; clear on the next edge -> flag = 0.
REQ-036 load = 1 and start = 1 with in = 8'h07 while in RUN -> count 7, state IDLE, no decrement.
REQ-037 reset_n pulsed low mid-RUN with INIT_VALUE = 8'h10 -> count = 8'h10 and running = 0 immediately (before any clock edge), flag = 0.
